// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-controller state encoding, peripheral
// register addresses and the default tx_en strobe length.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_PULSE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_IDLE = 3'd4
  } tx_state_t;

  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

  localparam int EN_CYCLES_DEFAULT = 325;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with occupancy count; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign level   = level_q;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rd_ptr_q];

  // Storage is never reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: buffers bytes in a FIFO and hands them one at a
// time to the sender with a fixed-length tx_en strobe, then waits for idle.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int EN_CYCLES = EN_CYCLES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       tx_status,
  input  logic                       clr_ovf,
  output logic [7:0]                 tx_data,
  output logic                       tx_en,
  output logic                       busy,
  output logic                       done,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       ovf,
  output logic [2:0]                 dbg_state
);

  localparam int CW = $clog2(EN_CYCLES);

  tx_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]  tx_data_q;
  logic        tx_en_q;
  logic        done_q;
  logic        ovf_q;
  logic        pop;
  logic        drop;
  logic [7:0]  head;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .pop   (pop),
    .wdata (wr_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign pop  = (state_q == S_LOAD);
  assign drop = wr_en && full && !pop;

  // Sender handshake: tx_en is a fixed-length strobe, not valid/ready; the
  // sender answers through tx_status (0 = busy, 1 = idle), which may already
  // be back at 1 by the time the strobe ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (!empty && tx_status) state_q <= S_LOAD;
        end
        S_LOAD: begin
          tx_data_q <= head;
          tx_en_q   <= 1'b1;
          cnt_q     <= CW'(EN_CYCLES - 1);
          state_q   <= S_PULSE;
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            tx_en_q <= 1'b0;
            cnt_q   <= CW'(EN_CYCLES - 1);
            state_q <= S_WAIT_BUSY;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_WAIT_BUSY: begin
          if (!tx_status || cnt_q == '0) state_q <= S_WAIT_IDLE;
          else                          cnt_q   <= cnt_q - CW'(1);
        end
        S_WAIT_IDLE: begin
          if (tx_status) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_en     = tx_en_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: FIFO fill vectors, single-byte and burst transfers
// against a sender model, load-cycle push, reset mid-strobe, stuck-idle sender.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int DEPTH = 8;
  localparam int EN    = 325;
  localparam int LW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          tx_status;
  logic          clr_ovf;
  logic [7:0]    tx_data;
  logic          tx_en;
  logic          busy;
  logic          done;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          ovf;
  logic [2:0]    dbg_state;

  logic          sender_auto;
  logic          man_status;
  logic          auto_status;

  assign tx_status = sender_auto ? auto_status : man_status;

  uart_tx_ctrl #(.DEPTH(DEPTH), .EN_CYCLES(EN)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .tx_status (tx_status),
    .clr_ovf   (clr_ovf),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .busy      (busy),
    .done      (done),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         en_pulses = 0;
  int         done_pulses = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Output monitor: byte order, strobe width, data stability, done pairing.
  int         hi_len = 0;
  logic       en_prev = 1'b0;
  logic       done_prev = 1'b0;
  logic       pend_done = 1'b0;
  logic [7:0] data_hold = '0;

  always @(negedge clk) begin
    if (reset) begin
      en_prev   = 1'b0;
      done_prev = 1'b0;
      pend_done = 1'b0;
      hi_len    = 0;
    end else begin
      if (tx_en) begin
        if (!en_prev) begin
          en_pulses++;
          hi_len = 0;
          check("no_done_between_pulses", 32'(pend_done), 32'd0);
          pend_done = 1'b1;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_byte: actual=%0h required=none queued", tx_data);
          end else begin
            check("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
          end
          data_hold = tx_data;
        end else begin
          check("tx_data_stable", 32'(tx_data), 32'(data_hold));
        end
        hi_len++;
      end else if (en_prev) begin
        check("tx_en_width", 32'(hi_len), 32'(EN));
      end
      if (done) begin
        done_pulses++;
        check("done_after_pulse", 32'(pend_done), 32'd1);
        check("done_single_cycle", 32'(done_prev), 32'd0);
        pend_done = 1'b0;
      end
      en_prev   = tx_en;
      done_prev = done;
    end
  end

  // Sender model: goes busy after each strobe for a random time.
  initial begin
    auto_status = 1'b1;
    forever begin
      @(negedge clk);
      if (sender_auto && tx_en) begin
        for (int k = 0; k < 2*EN && tx_en; k++) @(negedge clk);
        auto_status = 1'b0;
        repeat ($urandom_range(2, 15)) @(negedge clk);
        auto_status = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic expect_accept);
    wr_en   = 1'b1;
    wr_data = b;
    if (expect_accept) exp_q.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_tx_en(input logic lvl, input int max, input string name);
    int k;
    k = 0;
    while (tx_en !== lvl && k < max) begin
      tick();
      k++;
    end
    if (tx_en !== lvl) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: actual=timeout required=tx_en==%0d within %0d cycles", name, lvl, max);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic          wr;
    logic [7:0]    data;
    logic          clr;
    logic          acc;
    logic [LW-1:0] lvl;
    logic          full;
    logic          ovf;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int base_en, base_done, cnt;

    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 8'(i+1), 1'b0, 1'b1, LW'(i+1), (i == 7), 1'b0};
    vecs[8]  = '{1'b1, 8'h09, 1'b0, 1'b0, LW'(8), 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, LW'(8), 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, LW'(8), 1'b1, 1'b0};

    // ---- reset ----
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; clr_ovf = 1'b0;
    man_status = 1'b1; sender_auto = 1'b0;
    repeat (3) tick();
    check("rst_tx_en",  32'(tx_en),  32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_ovf",    32'(ovf),    32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_empty",  32'(empty),  32'd1);
    check("rst_full",   32'(full),   32'd0);
    check("rst_level",  32'(level),  32'd0);
    reset = 1'b0;
    tick();

    // ---- single byte with handshaking sender ----
    push_byte(8'h55, 1'b1);
    check("one_level_after_push", 32'(level), 32'd1);
    tick();
    check("one_state_load", 32'(dbg_state), 32'(S_LOAD));
    check("one_busy", 32'(busy), 32'd1);
    tick();
    check("one_tx_en_up", 32'(tx_en), 32'd1);
    check("one_tx_data", 32'(tx_data), 32'h55);
    check("one_level_after_pop", 32'(level), 32'd0);
    wait_tx_en(1'b0, 2*EN, "one_strobe_end");
    check("one_state_wait_busy", 32'(dbg_state), 32'(S_WAIT_BUSY));
    man_status = 1'b0;
    tick();
    check("one_state_wait_idle", 32'(dbg_state), 32'(S_WAIT_IDLE));
    repeat (3) tick();
    check("one_no_early_done", 32'(done), 32'd0);
    man_status = 1'b1;
    tick();
    check("one_done", 32'(done), 32'd1);
    check("one_idle_busy", 32'(busy), 32'd0);
    tick();
    check("one_done_drop", 32'(done), 32'd0);

    // ---- fill / overflow / clear vectors, sender busy ----
    man_status = 1'b0;
    for (int i = 0; i < 11; i++) begin
      wr_en   = vecs[i].wr;
      wr_data = vecs[i].data;
      clr_ovf = vecs[i].clr;
      if (vecs[i].acc) exp_q.push_back(vecs[i].data);
      tick();
      wr_en = 1'b0; clr_ovf = 1'b0;
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
      check($sformatf("vec%0d_full", i),  32'(full),  32'(vecs[i].full));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'd0);
      check($sformatf("vec%0d_ovf", i),   32'(ovf),   32'(vecs[i].ovf));
      check($sformatf("vec%0d_busy", i),  32'(busy),  32'd0);
    end

    // ---- push in the LOAD cycle of a full FIFO, then drain ----
    base_en = en_pulses; base_done = done_pulses;
    man_status = 1'b1;
    tick();
    check("ld_state_load", 32'(dbg_state), 32'(S_LOAD));
    push_byte(8'hAA, 1'b1);
    check("ld_level_kept", 32'(level), 32'd8);
    check("ld_ovf_clear", 32'(ovf), 32'd0);
    check("ld_state_pulse", 32'(dbg_state), 32'(S_PULSE));
    sender_auto = 1'b1;
    cnt = 0;
    while (done_pulses < base_done + 9 && cnt < 9*(2*EN+60)) begin
      tick();
      cnt++;
    end
    tick();
    check("drain_en_pulses", 32'(en_pulses - base_en), 32'd9);
    check("drain_done_pulses", 32'(done_pulses - base_done), 32'd9);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_level", 32'(level), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_queue_left", 32'(exp_q.size()), 32'd0);
    sender_auto = 1'b0;
    man_status  = 1'b1;

    // ---- reset in cycle 100 of a strobe ----
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    wait_tx_en(1'b1, 10, "rst_mid_strobe_start");
    repeat (99) tick();
    check("rst_mid_tx_en_before", 32'(tx_en), 32'd1);
    base_done = done_pulses;
    reset = 1'b1;
    tick();
    check("rst_mid_tx_en", 32'(tx_en), 32'd0);
    check("rst_mid_level", 32'(level), 32'd0);
    check("rst_mid_empty", 32'(empty), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_tx_data", 32'(tx_data), 32'd0);
    exp_q.delete();
    reset = 1'b0;
    repeat (5) tick();
    check("rst_mid_no_done", 32'(done_pulses - base_done), 32'd0);
    check("rst_mid_stays_idle", 32'(dbg_state), 32'(S_IDLE));

    // ---- sender never reports busy ----
    push_byte(8'h3C, 1'b1);
    wait_tx_en(1'b1, 10, "stuck_strobe_start");
    wait_tx_en(1'b0, 2*EN, "stuck_strobe_end");
    cnt = 0;
    while (dbg_state == 3'(S_WAIT_BUSY) && cnt < 2*EN) begin
      tick();
      cnt++;
    end
    check("stuck_wait_busy_cycles", 32'(cnt), 32'(EN));
    check("stuck_state_wait_idle", 32'(dbg_state), 32'(S_WAIT_IDLE));
    tick();
    check("stuck_done", 32'(done), 32'd1);
    tick();
    check("stuck_queue_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
